// File: rtl/flash_reader_if.sv
// flash_reader_if: read request/stream and SB_SPI register-port signals of the flash reader.
interface flash_reader_if;
  logic        start;
  logic [23:0] faddr;
  logic [7:0]  len;
  logic        busy;
  logic        valid;
  logic [7:0]  data;
  logic        ready;
  logic        en;
  logic        wr;
  logic [3:0]  sel;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  modport master (input start, faddr, len, ready, ack, rdata,
                  output busy, valid, data, en, wr, sel, wdata);
  modport slave  (output start, faddr, len, ready, ack, rdata,
                  input busy, valid, data, en, wr, sel, wdata);
endinterface

// File: rtl/flash_reader.sv
// flash_reader: configures SB_SPI after reset, then performs flash READs onto a valid/ready stream.
// Define FLASH_FAST_READ_EN for FAST READ (0x0B plus one dummy byte) instead of READ (0x03).
module flash_reader #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int SCLK_FREQ = 3_000_000
) (
  input logic           clk,
  input logic           rst_n,
  flash_reader_if.master bus
);
  localparam logic [3:0] SPICR1  = 4'h9;
  localparam logic [3:0] SPICR2  = 4'hA;
  localparam logic [3:0] SPIBR   = 4'hB;
  localparam logic [3:0] SPISR   = 4'hC;
  localparam logic [3:0] SPITXDR = 4'hD;
  localparam logic [3:0] SPIRXDR = 4'hE;
  localparam logic [3:0] SPICSR  = 4'hF;
  localparam logic [5:0] BR = 6'(CLK_FREQ / (2 * SCLK_FREQ) - 1);
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam logic [2:0] HDR = 3'd5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam logic [2:0] HDR = 3'd4;
`endif
  typedef enum logic [3:0] {INIT, IDLE, CS_ON, POLL_T, TX, POLL_R, RX, OUT, CS_OFF} state_t;
  state_t      state;
  logic [1:0]  step;
  logic [2:0]  hidx;
  logic [7:0]  cnt;
  logic [23:0] addr;
  logic        a_wr;
  logic [3:0]  a_sel;
  logic [7:0]  a_wdata, init_data, tx_data;
  // Access descriptor for the current state; latched onto the bus when en rises
  always_comb begin
    init_data = step == 2'd0 ? 8'h00 : step == 2'd1 ? 8'h80 : step == 2'd2 ? {2'b00, BR} : 8'hC0;
    tx_data   = hidx == 3'd0 ? CMD : hidx == 3'd1 ? addr[23:16] : hidx == 3'd2 ? addr[15:8] :
                hidx == 3'd3 ? addr[7:0] : 8'h00;
    a_wr      = state inside {INIT, CS_ON, TX, CS_OFF};
    a_sel     = state == INIT ? (step == 2'd0 ? SPICSR : step == 2'd1 ? SPICR1 : step == 2'd2 ? SPIBR : SPICR2) :
                state inside {POLL_T, POLL_R} ? SPISR : state == TX ? SPITXDR : state == RX ? SPIRXDR : SPICSR;
    a_wdata   = state == INIT ? init_data : state == TX ? tx_data : state == CS_ON ? 8'h01 : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      step      <= 2'd0;
      hidx      <= 3'd0;
      cnt       <= 8'd0;
      addr      <= 24'd0;
      bus.busy  <= 1'b1;
      bus.valid <= 1'b0;
      bus.data  <= 8'd0;
      bus.en    <= 1'b0;
      bus.wr    <= 1'b0;
      bus.sel   <= 4'd0;
      bus.wdata <= 8'd0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        addr     <= bus.faddr;
        cnt      <= bus.len;
        hidx     <= 3'd0;
        bus.busy <= 1'b1;
        state    <= CS_ON;
      end
    end else if (state == OUT) begin
      if (bus.ready) begin
        bus.valid <= 1'b0;
        state     <= cnt == 8'd0 ? CS_OFF : POLL_T;
        cnt       <= cnt == 8'd0 ? cnt : cnt - 8'd1;
      end
    end else if (!bus.en) begin
      bus.en    <= 1'b1;
      bus.wr    <= a_wr;
      bus.sel   <= a_sel;
      bus.wdata <= a_wdata;
    end else if (bus.ack) begin
      bus.en <= 1'b0;
      case (state)
        INIT: begin
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        CS_ON:  state <= POLL_T;
        POLL_T: if (bus.rdata[4]) state <= TX;
        TX:     state <= POLL_R;
        POLL_R: if (bus.rdata[3]) state <= RX;
        RX: begin
          if (hidx == HDR) begin
            bus.data  <= bus.rdata;
            bus.valid <= 1'b1;
            state     <= OUT;
          end else begin
            hidx  <= hidx + 3'd1;
            state <= POLL_T;
          end
        end
        CS_OFF: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: SB_SPI register-port model (2-cycle ack) plus SPI flash model around flash_reader.
module tb_flash_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  flash_reader_if bus();
  flash_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int HDR = 5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int HDR = 4;
`endif
  int checks = 0, passed = 0;
  logic ph = 1'b0, ack_r = 1'b0, rx_full = 1'b0;
  logic [7:0] rxd = 8'h00, m_cmd = 8'h00;
  logic [23:0] m_addr = 24'h0;
  int sbusy = 0, tx_idx = 0, sr_reads = 0, dst;
  logic [11:0] wlog[$];
  logic [7:0] mosi[$], csr[$], got[$];
  int hdr_viol = 0, stab_viol = 0, gap_viol = 0;
  logic p_en = 1'b0, p_ack = 1'b0;
  logic [12:0] p_fields = 13'h0;

  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'hA5;
  endfunction

  assign bus.ack   = ack_r;
  assign bus.rdata = bus.sel == 4'hC ? {3'b000, sbusy == 0, sbusy == 0 && rx_full, 3'b000} :
                     bus.sel == 4'hE ? rxd : 8'h00;
  always_comb dst = m_cmd == 8'h0B ? 5 : 4;

  // Register port and SPI shift engine: TX completes after two further status polls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 1'b0; ack_r <= 1'b0; rx_full <= 1'b0; sbusy <= 0;
    end else begin
      if (!bus.en) begin ph <= 1'b0; ack_r <= 1'b0; end
      else if (ack_r) ack_r <= 1'b0;
      else if (ph) ack_r <= 1'b1;
      else ph <= 1'b1;
      if (bus.en && ack_r) begin
        if (bus.wr) begin
          wlog.push_back({bus.sel, bus.wdata});
          if (bus.sel == 4'hF) begin csr.push_back(bus.wdata); tx_idx <= 0; end
          if (bus.sel == 4'hD) begin
            mosi.push_back(bus.wdata);
            if (tx_idx == 0) m_cmd <= bus.wdata;
            if (tx_idx == 1) m_addr[23:16] <= bus.wdata;
            if (tx_idx == 2) m_addr[15:8] <= bus.wdata;
            if (tx_idx == 3) m_addr[7:0] <= bus.wdata;
            rxd <= (tx_idx >= 4 && tx_idx >= dst) ? mem(m_addr + 24'(tx_idx - dst)) : 8'hFF;
            tx_idx <= tx_idx + 1; rx_full <= 1'b1; sbusy <= 2;
          end
        end else if (bus.sel == 4'hC) begin
          sr_reads <= sr_reads + 1;
          if (sbusy > 0) sbusy <= sbusy - 1;
        end else if (bus.sel == 4'hE) rx_full <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      p_en <= 1'b0; p_ack <= 1'b0;
    end else begin
      if (bus.valid && bus.ready) got.push_back(bus.data);
      if (bus.valid && tx_idx < HDR + 1) hdr_viol <= hdr_viol + 1;
      if (p_en && !p_ack && (!bus.en || {bus.wr, bus.sel, bus.wdata} != p_fields)) stab_viol <= stab_viol + 1;
      if (p_en && p_ack && bus.en) gap_viol <= gap_viol + 1;
      p_en <= bus.en; p_ack <= ack_r; p_fields <= {bus.wr, bus.sel, bus.wdata};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start(input logic [23:0] fa, input logic [7:0] ln);
    bus.faddr = fa; bus.len = ln; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    logic [11:0] exp_w[4];
    bit ok;
    exp_w = '{12'hF00, 12'h980, 12'hB07, 12'hAC0};
    tick(3);
    checks++; if (bus.en !== 1'b0) $display("FAIL reset_en: got %b want 0", bus.en); else passed++;
    checks++; if (bus.wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", bus.wr); else passed++;
    checks++; if (bus.sel !== 4'h0) $display("FAIL reset_sel: got %h want 0", bus.sel); else passed++;
    checks++; if (bus.wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", bus.wdata); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.data); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else passed++;
    @(negedge clk); rst_n = 1'b1;
    wait_idle(300, ok);
    checks++; if (ok !== 1'b1) $display("FAIL init_done: busy still %b want 0", bus.busy); else passed++;
    checks++; if (wlog.size() !== 4) $display("FAIL init_writes: got %0d want 4", wlog.size()); else passed++;
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== exp_w[i]) $display("FAIL init_write%0d: got %h want %h", i, wlog[i], exp_w[i]); else passed++;
    end
  endtask

  task automatic run_read(input logic [23:0] fa, input logic [7:0] ln, input bit disturb);
    logic [7:0] hx[5];
    int m0, g0, c0, n;
    bit ok;
    hx = '{CMD, fa[23:16], fa[15:8], fa[7:0], 8'h00};
    n = int'(ln) + 1;
    m0 = mosi.size(); g0 = got.size(); c0 = csr.size();
    bus.ready = 1'b1;
    pulse_start(fa, ln);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (disturb && (i == 20 || i == 60 || i == 100)) begin bus.faddr = 24'h777777; bus.len = 8'd9; bus.start = 1'b1; end
      tick(1);
      bus.start = 1'b0;
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) $display("FAIL read_done %h: busy still %b want 0", fa, bus.busy); else passed++;
    checks++; if (mosi.size() - m0 !== HDR + n) $display("FAIL mosi_count %h: got %0d want %0d", fa, mosi.size() - m0, HDR + n); else passed++;
    for (int i = 0; i < HDR && m0 + i < mosi.size(); i++) begin
      checks++; if (mosi[m0 + i] !== hx[i]) $display("FAIL mosi_hdr%0d %h: got %h want %h", i, fa, mosi[m0 + i], hx[i]); else passed++;
    end
    checks++; if (got.size() - g0 !== n) $display("FAIL byte_count %h: got %0d want %0d", fa, got.size() - g0, n); else passed++;
    for (int i = 0; i < n && g0 + i < got.size(); i++) begin
      checks++; if (got[g0 + i] !== mem(fa + 24'(i))) $display("FAIL data%0d %h: got %h want %h", i, fa, got[g0 + i], mem(fa + 24'(i))); else passed++;
    end
    checks++; if (csr.size() - c0 !== 2) $display("FAIL csr_count %h: got %0d want 2", fa, csr.size() - c0); else passed++;
    if (csr.size() - c0 == 2) begin
      checks++; if ({csr[c0], csr[c0 + 1]} !== 16'h0100) $display("FAIL csr_seq %h: got %h%h want 0100", fa, csr[c0], csr[c0 + 1]); else passed++;
    end
    if (disturb) begin
      tick(10);
      checks++; if (bus.busy !== 1'b0) $display("FAIL start_not_queued: busy %b want 0", bus.busy); else passed++;
    end
  endtask

  task automatic test_stall;
    logic [7:0] v0;
    int s0, g0, viol;
    bit ok;
    g0 = got.size();
    bus.ready = 1'b0;
    pulse_start(24'h00ABCD, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.valid) begin ok = 1'b1; break; end
      tick(1);
    end
    checks++; if (ok !== 1'b1) $display("FAIL stall_valid: valid %b want 1", bus.valid); else passed++;
    v0 = bus.data; s0 = sr_reads; viol = 0;
    checks++; if (v0 !== mem(24'h00ABCD)) $display("FAIL stall_data: got %h want %h", v0, mem(24'h00ABCD)); else passed++;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.valid !== 1'b1 || bus.data !== v0 || bus.en !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) $display("FAIL stall_hold: got %0d glitches want 0", viol); else passed++;
    checks++; if (sr_reads !== s0) $display("FAIL stall_polls: got %0d want %0d", sr_reads, s0); else passed++;
    bus.ready = 1'b1;
    wait_idle(500, ok);
    checks++; if (ok !== 1'b1) $display("FAIL stall_done: busy %b want 0", bus.busy); else passed++;
    checks++; if (got.size() - g0 !== 1) $display("FAIL stall_count: got %0d want 1", got.size() - g0); else passed++;
  endtask

  task automatic test_reset_mid;
    int g0, w0;
    bit ok;
    g0 = got.size();
    bus.ready = 1'b1;
    pulse_start(24'h020000, 8'd7);
    for (int i = 0; i < 5000 && got.size() - g0 < 2; i++) tick(1);
    checks++; if (got.size() - g0 < 2) $display("FAIL mid_progress: got %0d bytes want >=2", got.size() - g0); else passed++;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (bus.en !== 1'b0) $display("FAIL mid_en: got %b want 0", bus.en); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", bus.busy); else passed++;
    tick(2);
    w0 = wlog.size();
    @(negedge clk); rst_n = 1'b1;
    wait_idle(300, ok);
    checks++; if (ok !== 1'b1) $display("FAIL mid_reinit: busy %b want 0", bus.busy); else passed++;
    checks++; if (wlog.size() - w0 !== 4) $display("FAIL mid_writes: got %0d want 4", wlog.size() - w0); else passed++;
    if (wlog.size() > w0) begin
      checks++; if (wlog[w0] !== 12'hF00) $display("FAIL mid_first_write: got %h want F00", wlog[w0]); else passed++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.faddr = 24'h0; bus.len = 8'h0; bus.ready = 1'b0;
    test_reset;
    run_read(24'h012345, 8'd3, 1'b0);
    test_stall;
    run_read(24'h100200, 8'd2, 1'b1);
    run_read(24'hFFFF80, 8'd255, 1'b0);
`ifdef FLASH_FAST_READ_EN
    run_read(24'h000010, 8'd1, 1'b0);
`endif
    test_reset_mid;
    checks++; if (hdr_viol !== 0) $display("FAIL valid_in_header: got %0d want 0", hdr_viol); else passed++;
    checks++; if (stab_viol !== 0) $display("FAIL bus_stable: got %0d want 0", stab_viol); else passed++;
    checks++; if (gap_viol !== 0) $display("FAIL bus_gap: got %0d want 0", gap_viol); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
